// File: rtl/char_normalizer.sv
// Whitespace-canonicalising input stage with a DEPTH-entry FIFO feeding the begin/end checker.
// Optional build macro CHAR_NORM_LOWER_EN folds A-Z to a-z before buffering.
module char_normalizer #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] drop_cnt
);

    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          last_sp;

    logic       full;
    logic       empty;
    logic       take;
    logic       is_ws;
    logic       is_print;
    logic [7:0] mapped;
    logic       wr_en;
    logic       drop;
    logic       rd_en;

    // Pointer MSB separates the full and empty cases when the index bits match.
    assign full      = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out       = mem[rd_ptr[AW-1:0]];

    assign take  = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Byte classification and mapping to the canonical character.
    always_comb begin
        is_ws    = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
        is_print = (in >= 8'h21) && (in <= 8'h7E);
`ifdef CHAR_NORM_LOWER_EN
        if ((in >= 8'h41) && (in <= 8'h5A)) begin
            mapped = in + 8'h20;
        end else begin
            mapped = in;
        end
`else
        mapped = in;
`endif
        if (is_ws) begin
            mapped = 8'h20;
        end
    end

    // A space is only buffered when the previous buffered char was printable.
    assign wr_en = take && (is_print || (is_ws && !last_sp));
    assign drop  = take && !is_ws && !is_print;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_sp  <= 1'b1;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (take && is_ws) begin
                last_sp <= 1'b1;
            end else if (take && is_print) begin
                last_sp <= 1'b0;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= mapped;
        end
    end

endmodule

// File: tb/tb_char_normalizer.sv
// Directed bench for char_normalizer: table of byte streams plus hand sequences for
// latency, full/backpressure, pointer wrap and mid-stream reset.
module tb_char_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];

    char_normalizer #(.DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every char actually consumed by the downstream.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(out);
    end

    typedef struct {
        string name;
        string inp;
        string exp;
        int    drops;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        if (out_valid) check({name, "_drain_timeout"}, 1, 0);
    endtask

    function automatic string got_str();
        string s;
        s = "";
        foreach (got_q[i]) s = {s, $sformatf("%c", got_q[i])};
        return s;
    endfunction

    initial begin
        string tmp;
        int    accepted;

        reset = 1'b1;
        in = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{"ws_runs", "  begin\t\tend\n", "begin end ", 0};
`ifdef CHAR_NORM_LOWER_EN
        vecs[1] = '{"case", "BEGIN End", "begin end", 0};
        vecs[5] = '{"az_edges", "@AZ[ ] ", "@az[ ] ", 0};
`else
        vecs[1] = '{"case", "BEGIN End", "BEGIN End", 0};
        vecs[5] = '{"az_edges", "@AZ[ ] ", "@AZ[ ] ", 0};
`endif
        tmp = "...x";
        tmp.putc(0, 8'h01);
        tmp.putc(1, 8'h7F);
        tmp.putc(2, 8'hFF);
        vecs[2] = '{"nonprint", tmp, "x", 3};
        tmp = "a. b";
        tmp.putc(1, 8'h01);
        vecs[3] = '{"drop_keeps_sp", tmp, "a b", 1};
        vecs[4] = '{"only_ws", " \t\r\n", "", 0};

        @(posedge clk);
        #1;
        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_drop_cnt", int'(drop_cnt), 0);

        // Single-cycle latency through the FIFO.
        in = "q";
        in_valid = 1'b1;
        check("lat_pre_valid", int'(out_valid), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_valid", int'(out_valid), 1);
        check("lat_char", int'(out), int'("q"));

        // Table of streams, drained with out_ready held high.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            got_q.delete();
            out_ready = 1'b1;
            for (int i = 0; i < vecs[v].inp.len(); i++) begin
                in = vecs[v].inp.getc(i);
                in_valid = 1'b1;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            drain(vecs[v].name);
            check_str({vecs[v].name, "_out"}, got_str(), vecs[v].exp);
            check({vecs[v].name, "_drops"}, int'(drop_cnt), vecs[v].drops);
            out_ready = 1'b0;
        end

        // Fill to full with the downstream stalled.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            in = 8'(int'("a") + i);
            in_valid = 1'b1;
            if (in_ready) accepted++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("full_accepted", accepted, 8);
        check("full_in_ready", int'(in_ready), 0);
        check("full_head", int'(out), int'("a"));
        // Pop while full with a write offered: the write must be blocked.
        in = "z";
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        check("pop_in_ready", int'(in_ready), 1);
        check("pop_head", int'(out), int'("b"));
        got_q.delete();
        out_ready = 1'b1;
        drain("full");
        check_str("full_rest", got_str(), "bcdefgh");
        out_ready = 1'b0;

        // Half full, then 20 cycles of simultaneous push and pop across the pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(int'("a") + i));
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            in = 8'(int'("e") + j);
            in_valid = 1'b1;
            check($sformatf("wrap_head_%0d", j), int'(out_valid ? out : 8'h00), int'("a") + j);
            check($sformatf("wrap_in_ready_%0d", j), int'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        got_q.delete();
        drain("wrap");
        check_str("wrap_rest", got_str(), "uvwx");
        out_ready = 1'b0;

        // Reset with five chars buffered and one drop counted.
        do_reset();
        push("a");
        push("b");
        push(8'h01);
        push("c");
        push("d");
        push("e");
        check("mid_pre_drop", int'(drop_cnt), 1);
        reset = 1'b1;
        in = "q";
        in_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_drop_cnt", int'(drop_cnt), 0);
        check("mid_in_ready", int'(in_ready), 1);
        push(" ");
        check("mid_lead_sp", int'(out_valid), 0);
        push("k");
        check("mid_next_valid", int'(out_valid), 1);
        check("mid_next_char", int'(out), int'("k"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
